audio_sfx_scheduler: RTL and testbench
======================================

// Module: audio_sfx_scheduler
// PURPOSE
//   Schedules the shared audio sample ROM between looping background music (BGM) and one-shot
//   sound effects (gunshot, zombie hit, pickup, ...). Generates the ROM address Add at the
//   music_frequency sample rate, advancing only when the codec path has consumed a sample.
//   Effects pause BGM; BGM resumes at its saved address when the effect queue drains.
// PARAMETERS
//   N_SFX    4      number of effect requesters; index 0 = highest priority
//   ADDR_W   17     ROM address width
//   BGM_LEN  10000  BGM sample count; BGM occupies ROM addresses 0..BGM_LEN-1
// PORTS
//   Clk              in   1              system clock
//   Reset            in   1              synchronous, active-high
//   INIT_FINISH      in   1              codec init done; level, sampled every cycle
//   data_over        in   1              codec consumed current sample (level)
//   music_frequency  in   17             sample period minus 1, in Clk cycles
//   sfx_req          in   N_SFX          one-cycle request pulses
//   sfx_base         in   N_SFX*ADDR_W   effect i start address, bits [i*ADDR_W +: ADDR_W]
//   sfx_len          in   N_SFX*ADDR_W   effect i sample count, same packing
//   Add              out  ADDR_W         ROM sample address
//   sfx_active       out  1              1 while an effect owns Add
//   sfx_grant        out  N_SFX          one-hot: effect currently playing
//   sfx_done         out  N_SFX          one-cycle pulse when effect i finishes
//   sample_tick      out  1              one-cycle pulse on every address advance
// BEHAVIOUR
//   Reset: state=WAIT; Add=0; sfx_active=0; sfx_grant=0; sfx_done=0; sample_tick=0;
//     pending=0; tick counter=0; saved BGM address=0. Reset mid-effect aborts the effect
//     with no sfx_done pulse.
//   Tick counter (17 bits): counts 0..music_frequency. tick=1 on the cycle counter>=music_frequency;
//     counter then returns to 0. The >= comparison handles a frequency decrease mid-count.
//     Counter runs in all states except WAIT. tick is internal.
//   Advance = tick & data_over. If tick occurs with data_over=0, no advance; the next tick is
//     one full period later. sample_tick is registered: it is 1 on the cycle after the edge that
//     changes Add.
//   Pending: pending[i] is set by sfx_req[i]. It is cleared when effect i is granted.
//     A request for the effect now playing restarts it at its base address on the next cycle.
//     That restart produces no sfx_done pulse and leaves pending unchanged.
//     Requests arriving in WAIT are latched.
//   FSM:
//     WAIT: Add held at 0. Goes to BGM on the cycle after INIT_FINISH=1.
//     BGM: on advance, Add<=Add+1, with wrap to 0 when Add==BGM_LEN-1.
//       If pending!=0: grant the lowest set index k in the next cycle. Save the current BGM
//       address (a tick in the same cycle is applied first). Set Add<=base[k],
//       remain[k]<=len[k], sfx_grant<=1<<k, sfx_active<=1. Counter reset to 0. Go to SFX.
//     SFX: on advance, Add<=Add+1 and remain<=remain-1.
//       Effect ends on the advance where remain==1; the next cycle pulses sfx_done[k].
//       If the effect is granted with len=0, it ends on the cycle after the grant.
//       End of effect, pending!=0: grant the next effect directly (SFX->SFX). BGM stays saved.
//       End of effect, pending==0: Add<=saved BGM address, grant=0, active=0, go to BGM.
//       Higher-priority requests never preempt a playing effect; they wait in pending.
//   Latency: sfx_req at cycle t (state BGM, nothing pending) -> Add=base, grant valid at t+2.
//   Width rules: Add+1 wraps modulo 2^ADDR_W inside effects; base+len overflow is the
//     requester's error.
//   Addresses are unsigned. INIT_FINISH dropping after WAIT is ignored.
// TESTING
//   1 Reset, INIT_FINISH=1, music_frequency=3, data_over=1 -> Add steps 0,1,2... one step per
//     4 clocks, sample_tick pulses every 4 clocks.
//   2 BGM at Add=9999 (BGM_LEN=10000), advance -> Add=0. Hold data_over=0 for 3 ticks -> Add
//     stays frozen, then resumes stepping.
//   3 BGM Add=500, sfx_req[2] with base=20000, len=5 -> Add=20000..20004, sfx_done[2] pulse
//     after 5th advance, Add returns to 500.
//   4 Simultaneous sfx_req[1] and sfx_req[3] during playing effect 2 -> after 2 completes,
//     effect 1 plays, then 3, with no BGM address between them. Then BGM resumes at the saved
//     address.
//   5 sfx_req[0] during its own playback at remain=2 -> Add restarts at base[0], no sfx_done;
//     len=0 request -> sfx_done one cycle after grant, Add unchanged.
//   6 Assert Reset mid-effect -> all outputs 0, state WAIT, no sfx_done pulse, pending cleared.

Source files
------------

// File: rtl/audio_sfx_scheduler.sv
// rtl/audio_sfx_scheduler.sv - shares one sample ROM between looping BGM and prioritised one-shot effects
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   INIT_FINISH       codec init done; leaves WAIT on the cycle after it is seen high
//   data_over         codec consumed the current sample; gates every address advance
//   music_frequency   sample period minus 1, in Clk cycles
//   sfx_req           one-cycle request pulses, index 0 = highest priority
//   sfx_base/sfx_len  packed per-effect start address / sample count (ADDR_W bits each)
//   Add               ROM sample address
//   sfx_active        an effect currently owns Add
//   sfx_grant         one-hot effect currently playing
//   sfx_done          one-cycle pulse when an effect finishes
//   sample_tick       one-cycle pulse in the cycle a new Add value appears
module audio_sfx_scheduler #(
    parameter int N_SFX   = 4,
    parameter int ADDR_W  = 17,
    parameter int BGM_LEN = 10000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    INIT_FINISH,
    input  logic                    data_over,
    input  logic [16:0]             music_frequency,
    input  logic [N_SFX-1:0]        sfx_req,
    input  logic [N_SFX*ADDR_W-1:0] sfx_base,
    input  logic [N_SFX*ADDR_W-1:0] sfx_len,
    output logic [ADDR_W-1:0]       Add,
    output logic                    sfx_active,
    output logic [N_SFX-1:0]        sfx_grant,
    output logic [N_SFX-1:0]        sfx_done,
    output logic                    sample_tick
);

    localparam int IDX_W = (N_SFX > 1) ? $clog2(N_SFX) : 1;
    localparam logic [ADDR_W-1:0] BGM_LAST = ADDR_W'(BGM_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_BGM  = 2'd1,
        S_SFX  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  add_q, add_n;
    logic [ADDR_W-1:0]  saved_q, saved_n;
    logic [ADDR_W-1:0]  remain_q, remain_n;
    logic [16:0]        cnt_q, cnt_n;
    logic [N_SFX-1:0]   pending_q, pending_n;
    logic [IDX_W-1:0]   cur_q, cur_n;
    logic [N_SFX-1:0]   grant_q, grant_n;
    logic               active_q, active_n;
    logic [N_SFX-1:0]   done_q, done_n;
    logic               stick_q, stick_n;

    logic               tick, advance, do_grant, pick_valid;
    logic [IDX_W-1:0]   pick;
    logic [N_SFX-1:0]   pick_onehot, cur_onehot;
    logic [ADDR_W-1:0]  pick_base, pick_len, cur_base, cur_len, bgm_next;

    // Lowest set pending index wins.
    always_comb begin
        pick       = '0;
        pick_valid = |pending_q;
        for (int i = N_SFX - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick = IDX_W'(i);
            end
        end
    end

    assign pick_onehot = N_SFX'(1) << pick;
    assign cur_onehot  = N_SFX'(1) << cur_q;
    assign pick_base   = sfx_base[pick * ADDR_W +: ADDR_W];
    assign pick_len    = sfx_len[pick * ADDR_W +: ADDR_W];
    assign cur_base    = sfx_base[cur_q * ADDR_W +: ADDR_W];
    assign cur_len     = sfx_len[cur_q * ADDR_W +: ADDR_W];

    // >= rather than == so a period shortened mid-count still fires at once.
    assign tick     = (state != S_WAIT) && (cnt_q >= music_frequency);
    assign advance  = tick && data_over;
    assign bgm_next = (add_q == BGM_LAST) ? '0 : add_q + ONE;

    always_comb begin
        state_n   = state;
        add_n     = add_q;
        saved_n   = saved_q;
        remain_n  = remain_q;
        cur_n     = cur_q;
        grant_n   = grant_q;
        active_n  = active_q;
        done_n    = '0;
        stick_n   = advance;
        pending_n = pending_q | sfx_req;
        cnt_n     = (state == S_WAIT || tick) ? 17'd0 : cnt_q + 17'd1;
        do_grant  = 1'b0;

        case (state)
            S_WAIT: begin
                if (INIT_FINISH) begin
                    state_n = S_BGM;
                end
            end
            S_BGM: begin
                if (advance) begin
                    add_n = bgm_next;
                end
                if (pick_valid) begin
                    // Resume point includes an advance landing in this same cycle.
                    saved_n  = advance ? bgm_next : add_q;
                    do_grant = 1'b1;
                end
            end
            S_SFX: begin
                if (sfx_req[cur_q]) begin
                    // Retrigger of the playing effect: restart silently, no pending bit.
                    add_n     = cur_base;
                    remain_n  = cur_len;
                    cnt_n     = 17'd0;
                    pending_n = pending_q | (sfx_req & ~cur_onehot);
                end else if (remain_q == '0 || (advance && remain_q == ONE)) begin
                    done_n = cur_onehot;
                    if (pick_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        add_n    = saved_q;
                        grant_n  = '0;
                        active_n = 1'b0;
                        state_n  = S_BGM;
                    end
                end else if (advance) begin
                    add_n    = add_q + ONE;
                    remain_n = remain_q - ONE;
                end
            end
            default: begin
                state_n = S_WAIT;
            end
        endcase

        if (do_grant) begin
            add_n     = pick_base;
            remain_n  = pick_len;
            cur_n     = pick;
            grant_n   = pick_onehot;
            active_n  = 1'b1;
            cnt_n     = 17'd0;
            pending_n = (pending_q & ~pick_onehot) | sfx_req;
            state_n   = S_SFX;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_WAIT;
            add_q     <= '0;
            saved_q   <= '0;
            remain_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            cur_q     <= '0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            done_q    <= '0;
            stick_q   <= 1'b0;
        end else begin
            state     <= state_n;
            add_q     <= add_n;
            saved_q   <= saved_n;
            remain_q  <= remain_n;
            cnt_q     <= cnt_n;
            pending_q <= pending_n;
            cur_q     <= cur_n;
            grant_q   <= grant_n;
            active_q  <= active_n;
            done_q    <= done_n;
            stick_q   <= stick_n;
        end
    end

    assign Add         = add_q;
    assign sfx_active  = active_q;
    assign sfx_grant   = grant_q;
    assign sfx_done    = done_q;
    assign sample_tick = stick_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// tb/tb_audio_sfx_scheduler.sv - scoreboard bench for audio_sfx_scheduler
module tb_audio_sfx_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        INIT_FINISH;
    logic        data_over;
    logic [16:0] music_frequency;
    logic [3:0]  sfx_req;
    logic [67:0] sfx_base;
    logic [67:0] sfx_len;
    logic [16:0] Add;
    logic        sfx_active;
    logic [3:0]  sfx_grant;
    logic [3:0]  sfx_done;
    logic        sample_tick;

    audio_sfx_scheduler #(.N_SFX(4), .ADDR_W(17), .BGM_LEN(10000)) dut (
        .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .data_over(data_over),
        .music_frequency(music_frequency), .sfx_req(sfx_req), .sfx_base(sfx_base),
        .sfx_len(sfx_len), .Add(Add), .sfx_active(sfx_active), .sfx_grant(sfx_grant),
        .sfx_done(sfx_done), .sample_tick(sample_tick)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [16:0] add;
        logic [3:0]  done;
        logic [3:0]  grant;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic wait_tick(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 40 && !ok) begin
            @(negedge Clk);
            cycles++;
            if (sample_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic set_sfx(input int i, input logic [16:0] base, input logic [16:0] len);
        sfx_base[i*17 +: 17] = base;
        sfx_len[i*17 +: 17]  = len;
    endtask

    task automatic pulse(input logic [3:0] mask);
        sfx_req = mask;
        @(negedge Clk);
        sfx_req = 4'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b1; music_frequency = 17'd3;
        sfx_req = '0; sfx_base = '0; sfx_len = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if (Add !== 17'd0 || sfx_active !== 1'b0 || sfx_grant !== 4'd0 || sfx_done !== 4'd0 || sample_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: add=%0d act=%b grant=%b done=%b tick=%b, required all zero", Add, sfx_active, sfx_grant, sfx_done, sample_tick);
        end
        begin
            bit moved = 1'b0;
            repeat (8) begin
                @(negedge Clk);
                if (Add !== 17'd0 || sample_tick !== 1'b0) moved = 1'b1;
            end
            n_checks++;
            if (moved) begin
                n_fail++;
                $display("FAIL wait_hold: add=%0d tick=%b, required Add 0 with no tick in WAIT", Add, sample_tick);
            end
        end
    endtask

    task automatic test_bgm_step;
        int gap; bit ok; exp_t e;
        INIT_FINISH = 1'b1;
        for (int i = 1; i <= 5; i++) sb.push_back('{add: 17'(i), done: 4'd0, grant: 4'd0});
        for (int k = 0; sb.size() > 0; k++) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add || sfx_grant !== e.grant || sfx_done !== e.done) begin
                n_fail++;
                $display("FAIL bgm_step: ok=%b add=%0d grant=%b done=%b, required add=%0d", ok, Add, sfx_grant, sfx_done, e.add);
            end
            n_checks++;
            if (gap != ((k == 0) ? 5 : 4)) begin
                n_fail++;
                $display("FAIL bgm_period: gap=%0d, required %0d", gap, (k == 0) ? 5 : 4);
            end
        end
    endtask

    task automatic test_wrap_and_freeze;
        int gap; bit ok; exp_t e; logic [16:0] a; bit moved;
        music_frequency = 17'd0;
        ok = 1'b0;
        for (int c = 0; c < 12000 && !ok; c++) begin
            @(negedge Clk);
            if (Add === 17'd9998) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_9998: add=%0d, required 9998 within budget", Add);
        end
        sb.push_back('{add: 17'd9999, done: 4'd0, grant: 4'd0});
        sb.push_back('{add: 17'd0, done: 4'd0, grant: 4'd0});
        sb.push_back('{add: 17'd1, done: 4'd0, grant: 4'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add) begin
                n_fail++;
                $display("FAIL bgm_wrap: ok=%b add=%0d, required %0d", ok, Add, e.add);
            end
        end
        music_frequency = 17'd3;
        data_over = 1'b0;
        a = Add;
        moved = 1'b0;
        repeat (14) begin
            @(negedge Clk);
            if (Add !== a || sample_tick !== 1'b0) moved = 1'b1;
        end
        n_checks++;
        if (moved) begin
            n_fail++;
            $display("FAIL freeze: add=%0d tick=%b, required add=%0d and no tick", Add, sample_tick, a);
        end
        data_over = 1'b1;
        sb.push_back('{add: a + 17'd1, done: 4'd0, grant: 4'd0});
        sb.push_back('{add: a + 17'd2, done: 4'd0, grant: 4'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add) begin
                n_fail++;
                $display("FAIL resume: ok=%b add=%0d, required %0d", ok, Add, e.add);
            end
        end
    endtask

    task automatic test_single_sfx;
        int gap; bit ok; exp_t e; bit first;
        music_frequency = 17'd0;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge Clk);
            if (Add === 17'd500) begin
                ok = 1'b1;
                data_over = 1'b0;
            end
        end
        music_frequency = 17'd3;
        set_sfx(2, 17'd20000, 17'd5);
        pulse(4'b0100);
        n_checks++;
        if (Add !== 17'd500 || sfx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL sfx_latency: add=%0d act=%b, required add=500 act=0 one cycle after request", Add, sfx_active);
        end
        @(negedge Clk);
        n_checks++;
        if (Add !== 17'd20000 || sfx_grant !== 4'b0100 || sfx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL sfx_grant: add=%0d grant=%b act=%b, required 20000/0100/1", Add, sfx_grant, sfx_active);
        end
        data_over = 1'b1;
        for (int i = 1; i <= 4; i++) sb.push_back('{add: 17'(20000 + i), done: 4'd0, grant: 4'b0100});
        sb.push_back('{add: 17'd500, done: 4'b0100, grant: 4'd0});
        sb.push_back('{add: 17'd501, done: 4'd0, grant: 4'd0});
        first = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add || sfx_grant !== e.grant || sfx_done !== e.done) begin
                n_fail++;
                $display("FAIL single_sfx: ok=%b add=%0d grant=%b done=%b, required add=%0d grant=%b done=%b", ok, Add, sfx_grant, sfx_done, e.add, e.grant, e.done);
            end
            if (first) begin
                n_checks++;
                if (gap != 4) begin
                    n_fail++;
                    $display("FAIL sfx_first_period: gap=%0d, required 4", gap);
                end
                first = 1'b0;
            end
            if (e.done != 4'd0) begin
                @(negedge Clk);
                n_checks++;
                if (sfx_done !== 4'd0 || sfx_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_width: done=%b act=%b, required 0000/0", sfx_done, sfx_active);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int gap; bit ok; exp_t e; logic [16:0] bgm;
        set_sfx(1, 17'd30000, 17'd2);
        set_sfx(3, 17'd40000, 17'd3);
        data_over = 1'b0;
        bgm = Add;
        pulse(4'b0100);
        @(negedge Clk);
        n_checks++;
        if (Add !== 17'd20000 || sfx_grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_grant: add=%0d grant=%b, required 20000/0100", Add, sfx_grant);
        end
        data_over = 1'b1;
        pulse(4'b1010);
        for (int i = 1; i <= 4; i++) sb.push_back('{add: 17'(20000 + i), done: 4'd0, grant: 4'b0100});
        sb.push_back('{add: 17'd30000, done: 4'b0100, grant: 4'b0010});
        sb.push_back('{add: 17'd30001, done: 4'd0, grant: 4'b0010});
        sb.push_back('{add: 17'd40000, done: 4'b0010, grant: 4'b1000});
        sb.push_back('{add: 17'd40001, done: 4'd0, grant: 4'b1000});
        sb.push_back('{add: 17'd40002, done: 4'd0, grant: 4'b1000});
        sb.push_back('{add: bgm, done: 4'b1000, grant: 4'd0});
        sb.push_back('{add: bgm + 17'd1, done: 4'd0, grant: 4'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add || sfx_grant !== e.grant || sfx_done !== e.done) begin
                n_fail++;
                $display("FAIL back_to_back: ok=%b add=%0d grant=%b done=%b, required add=%0d grant=%b done=%b", ok, Add, sfx_grant, sfx_done, e.add, e.grant, e.done);
            end
        end
    endtask

    task automatic test_restart_and_zero_len;
        int gap; bit ok; exp_t e; logic [16:0] bgm;
        set_sfx(0, 17'd50000, 17'd4);
        data_over = 1'b0;
        bgm = Add;
        pulse(4'b0001);
        @(negedge Clk);
        n_checks++;
        if (Add !== 17'd50000 || sfx_grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL restart_grant: add=%0d grant=%b, required 50000/0001", Add, sfx_grant);
        end
        data_over = 1'b1;
        sb.push_back('{add: 17'd50001, done: 4'd0, grant: 4'b0001});
        sb.push_back('{add: 17'd50002, done: 4'd0, grant: 4'b0001});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add || sfx_grant !== e.grant || sfx_done !== e.done) begin
                n_fail++;
                $display("FAIL pre_restart: ok=%b add=%0d, required %0d", ok, Add, e.add);
            end
        end
        pulse(4'b0001);
        n_checks++;
        if (Add !== 17'd50000 || sfx_done !== 4'd0 || sfx_grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL restart: add=%0d done=%b grant=%b, required 50000/0000/0001", Add, sfx_done, sfx_grant);
        end
        for (int i = 1; i <= 3; i++) sb.push_back('{add: 17'(50000 + i), done: 4'd0, grant: 4'b0001});
        sb.push_back('{add: bgm, done: 4'b0001, grant: 4'd0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(gap, ok);
            n_checks++;
            if (!ok || Add !== e.add || sfx_grant !== e.grant || sfx_done !== e.done) begin
                n_fail++;
                $display("FAIL post_restart: ok=%b add=%0d grant=%b done=%b, required add=%0d grant=%b done=%b", ok, Add, sfx_grant, sfx_done, e.add, e.grant, e.done);
            end
        end
        set_sfx(3, 17'd60000, 17'd0);
        data_over = 1'b0;
        bgm = Add;
        pulse(4'b1000);
        @(negedge Clk);
        n_checks++;
        if (Add !== 17'd60000 || sfx_grant !== 4'b1000 || sfx_done !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_len_grant: add=%0d grant=%b done=%b, required 60000/1000/0000", Add, sfx_grant, sfx_done);
        end
        @(negedge Clk);
        n_checks++;
        if (sfx_done !== 4'b1000 || Add !== bgm || sfx_grant !== 4'd0 || sfx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%b add=%0d grant=%b act=%b, required 1000/%0d/0000/0", sfx_done, Add, sfx_grant, sfx_active, bgm);
        end
        @(negedge Clk);
        n_checks++;
        if (sfx_done !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_len_pulse: done=%b, required 0000", sfx_done);
        end
    endtask

    task automatic test_reset_mid_effect;
        int gap; bit ok; bit bad;
        data_over = 1'b0;
        pulse(4'b0100);
        @(negedge Clk);
        data_over = 1'b1;
        wait_tick(gap, ok);
        wait_tick(gap, ok);
        n_checks++;
        if (!ok || Add !== 17'd20002 || sfx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_effect_setup: ok=%b add=%0d act=%b, required 20002/1", ok, Add, sfx_active);
        end
        pulse(4'b0010);
        Reset = 1'b1;
        INIT_FINISH = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++;
        if (Add !== 17'd0 || sfx_active !== 1'b0 || sfx_grant !== 4'd0 || sfx_done !== 4'd0 || sample_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: add=%0d act=%b grant=%b done=%b tick=%b, required all zero", Add, sfx_active, sfx_grant, sfx_done, sample_tick);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            if (sfx_done !== 4'd0 || Add !== 17'd0 || sample_tick !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_wait: add=%0d done=%b tick=%b, required WAIT with no done", Add, sfx_done, sample_tick);
        end
        INIT_FINISH = 1'b1;
        data_over = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (sfx_active !== 1'b0 || sfx_grant !== 4'd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_pending: act=%b grant=%b, required no grant after reset", sfx_active, sfx_grant);
        end
    endtask

    initial begin
        test_reset;
        test_bgm_step;
        test_wrap_and_freeze;
        test_single_sfx;
        test_back_to_back;
        test_restart_and_zero_len;
        test_reset_mid_effect;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
